// File: rtl/booth_radix4_seq_mult_if.sv
// Handshake/operand bundle for booth_radix4_seq_mult.
//   start, tc, a, b : requester -> multiplier (sampled when ready=1)
//   ready, done, p  : multiplier -> requester
// master : the requester side; slave : the multiplier.
interface booth_radix4_seq_mult_if #(
  parameter int unsigned N = 8
);
  logic           start;
  logic           tc;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           ready;
  logic           done;
  logic [2*N-1:0] p;

  modport master (output start, tc, a, b, input ready, done, p);
  modport slave  (input start, tc, a, b, output ready, done, p);
endinterface

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one Booth digit per clock.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of booth_radix4_seq_mult_if
//            start/tc/a/b in, accepted on an edge with start & ready
//            ready : high in idle and done states
//            done  : one-cycle pulse, p valid while high
//            p     : exact 2N-bit product, signed or unsigned per latched tc
// Latency: done is high in the cycle after acceptance edge + N/2+1.
module booth_radix4_seq_mult #(
  parameter int unsigned N = 8
) (
  input logic                      clk,
  input logic                      rst,
  booth_radix4_seq_mult_if.slave   bus
);

  localparam int unsigned D  = N / 2 + 1;   // Booth digits per product
  localparam int unsigned W  = N + 2;       // extended operand width
  localparam int unsigned AW = 2 * N + 4;   // accumulator width
  localparam int unsigned CW = $clog2(D + 1);

  if ((N % 2) != 0 || N < 4) begin : g_bad_n
    $error("booth_radix4_seq_mult: N must be even and >= 4");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q;
  logic [W:0]     b_q;      // extended multiplier with the implicit b[-1]=0 at bit 0
  logic [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q;
  logic           load, step;

  // Booth digit decode of the current triplet, which always sits in b_q[2:0].
  logic           pp_zero, pp_two, pp_neg;
  logic [AW-1:0]  a_sx, pp_mag, pp_opnd;

  always_comb begin
    pp_zero = 1'b0;
    pp_two  = 1'b0;
    pp_neg  = 1'b0;
    unique case (b_q[2:0])
      3'b000, 3'b111: pp_zero = 1'b1;
      3'b001, 3'b010: ;
      3'b011:         pp_two  = 1'b1;
      3'b100: begin
        pp_two = 1'b1;
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: pp_neg  = 1'b1;
      default:        pp_zero = 1'b1;
    endcase
  end

  // Single shared adder; negation is invert plus carry-in. Inverting the
  // shifted magnitude still yields -(mag << 2i) modulo 2^AW.
  always_comb begin
    a_sx    = {{(AW - W){a_q[W-1]}}, a_q};
    pp_mag  = pp_zero ? '0 : (pp_two ? (a_sx << 1) : a_sx);
    pp_mag  = pp_mag << {cnt_q, 1'b0};
    pp_opnd = pp_neg ? ~pp_mag : pp_mag;
    acc_d   = acc_q + pp_opnd + AW'(pp_neg && !pp_zero);
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        step = 1'b1;
        if (cnt_q == CW'(D - 1)) state_d = StDone;
      end
      StDone: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q   <= bus.tc ? {{2{bus.a[N-1]}}, bus.a} : {2'b00, bus.a};
        b_q   <= {(bus.tc ? {{2{bus.b[N-1]}}, bus.b} : {2'b00, bus.b}), 1'b0};
        acc_q <= '0;
        cnt_q <= '0;
      end else if (step) begin
        acc_q <= acc_d;
        b_q   <= b_q >> 2;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.ready = (state_q != StCalc);
  assign bus.done  = (state_q == StDone);
  assign bus.p     = acc_q[2*N-1:0];

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
module tb_booth_radix4_seq_mult;
  localparam int N  = 8;
  localparam int PW = 2 * N;
  localparam int LAT = N / 2 + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_radix4_seq_mult_if #(.N(N)) bus ();
  booth_radix4_seq_mult #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [PW-1:0] model(input logic tc, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    longint x, y;
    x = tc ? longint'($signed(a)) : longint'(a);
    y = tc ? longint'($signed(b)) : longint'(b);
    return PW'(x * y);
  endfunction

  // Present operands with start for one edge; returns #1 after the accept edge.
  task automatic issue(input logic tc, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.tc    = tc;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = N'($urandom);
    bus.b     = N'($urandom);
    bus.tc    = 1'($urandom);
  endtask

  // Wait (bounded) for done; checks edges taken, ready low while busy, and p.
  task automatic wait_done(input string tag, input int exp_lat, input logic [PW-1:0] exp_p);
    int  lat = 0;
    bit  ready_bad = 0;
    for (int k = 1; k <= 4 * LAT; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.ready) ready_bad = 1;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " ready_busy"}, 64'(ready_bad), 64'd0);
    check({tag, " p"}, 64'(bus.p), 64'(exp_p));
    check({tag, " ready_done"}, 64'(bus.ready), 64'd1);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) n++;
    end
    check({tag, " no_extra_done"}, 64'(n), 64'd0);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic         rtc;
    logic [N-1:0] edge_vals [5];
    edge_vals[0] = 8'h80; edge_vals[1] = 8'h7F; edge_vals[2] = 8'hFF;
    edge_vals[3] = 8'h00; edge_vals[4] = 8'h01;

    bus.start = 1'b0;
    bus.tc    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    #12;
    check("reset ready", 64'(bus.ready), 64'd1);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset p", 64'(bus.p), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors.
    issue(1'b1, 8'hA9, 8'h03);
    check("s_a9x03 p_calc", 64'(bus.p), 64'd0);
    wait_done("s_a9x03", LAT, 16'hFEFB);
    @(posedge clk); #1;
    check("s_a9x03 p_hold", 64'(bus.p), 64'hFEFB);
    check("s_a9x03 done_pulse", 64'(bus.done), 64'd0);

    issue(1'b0, 8'hA9, 8'h03);
    wait_done("u_a9x03", LAT, 16'h01FB);
    issue(1'b0, 8'hFF, 8'hFF);
    wait_done("u_ffxff", LAT, 16'hFE01);
    issue(1'b1, 8'h80, 8'h80);
    wait_done("s_80x80", LAT, 16'h4000);
    issue(1'b1, 8'h80, 8'h7F);
    wait_done("s_80x7f", LAT, 16'hC080);
    issue(1'b1, 8'h00, 8'hA9);
    wait_done("s_00xa9", LAT, 16'h0000);

    // start pulsed mid-CALC must be ignored.
    issue(1'b1, 8'hA9, 8'h03);
    repeat (2) @(posedge clk);
    #1;
    bus.tc = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("ignore_start", LAT - 3, 16'hFEFB);
    count_done("ignore_start", 8);

    // Back-to-back issue with start held through DONE.
    issue(1'b1, 8'hA9, 8'h03);
    wait_done("b2b_first", LAT, 16'hFEFB);
    bus.tc = 1'b1; bus.a = 8'h05; bus.b = 8'hFD; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b reenter_ready", 64'(bus.ready), 64'd0);
    check("b2b reenter_done", 64'(bus.done), 64'd0);
    wait_done("b2b_second", LAT, 16'hFFF1);
    count_done("b2b", 8);

    // Asynchronous reset mid-CALC.
    issue(1'b0, 8'hA9, 8'h03);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst ready", 64'(bus.ready), 64'd1);
    check("arst done", 64'(bus.done), 64'd0);
    check("arst p", 64'(bus.p), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    count_done("arst", 8);
    issue(1'b0, 8'h07, 8'h09);
    wait_done("after_rst", LAT, 16'h003F);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 60; i++) begin
      rtc = 1'($urandom);
      ra  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : N'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : N'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      check($sformatf("rnd%0d ready", i), 64'(bus.ready), 64'd1);
      issue(rtc, ra, rb);
      wait_done($sformatf("rnd%0d tc=%0d a=%0h b=%0h", i, rtc, ra, rb), LAT,
                model(rtc, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
